// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state type and burst-length helpers for the
// AHB burst manager and its address generator.
package ahb_pkg;

  localparam int unsigned AHB_ADDR_WIDTH = 32;
  localparam int unsigned AHB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {
    HS_BYTE  = 3'd0,
    HS_HALF  = 3'd1,
    HS_WORD  = 3'd2,
    HS_DWORD = 3'd3,
    HS_QWORD = 3'd4,
    HS_OWORD = 3'd5,
    HS_512   = 3'd6,
    HS_1024  = 3'd7
  } hsize_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_BURST = 3'd2,
    S_LAST  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // len only matters for undefined-length INCR bursts
  function automatic logic [4:0] burst_beats(hburst_t burst, logic [4:0] len);
    case (burst)
      HB_SINGLE:          return 5'd1;
      HB_INCR:            return len;
      HB_WRAP4, HB_INCR4: return 5'd4;
      HB_WRAP8, HB_INCR8: return 5'd8;
      default:            return 5'd16;
    endcase
  endfunction

  function automatic logic is_wrap(hburst_t burst);
    return (burst == HB_WRAP4) || (burst == HB_WRAP8) || (burst == HB_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Combinational next-beat address: linear increment by the transfer size,
// folded back inside the (beats << size) aligned window for WRAP bursts.
module ahb_addr_gen import ahb_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = AHB_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [2:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    incr      = ADDR_WIDTH'(1) << size;
    incr_addr = addr + incr;
    wrap_mask = (ADDR_WIDTH'(burst_beats(hburst_t'(burst), 5'd1)) << size) - ADDR_WIDTH'(1);
    if (is_wrap(hburst_t'(burst))) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      next_addr = incr_addr;
    end
  end

endmodule

// File: rtl/ahb_burst_manager.sv
// AHB-Lite burst master: accepts one command at a time and drives a pipelined
// SINGLE/INCR/WRAP burst, reporting data beats, completion and error aborts.
module ahb_burst_manager import ahb_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = AHB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = AHB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic [4:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ack,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            HTRANS,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  state_t                state_q, state_d;
  htrans_t               htrans_q, htrans_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d, next_addr;
  logic                  hwrite_q, hwrite_d;
  hsize_t                hsize_q, hsize_d;
  hburst_t               hburst_q, hburst_d;
  logic [4:0]            left_q, left_d;
  logic                  dphase_q, dphase_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [4:0]            cmd_beats;
  logic [11:0]           end_off;
  logic                  cmd_bad;
  logic                  to_idle;

  ahb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (haddr_q),
    .size      (hsize_q),
    .burst     (hburst_q),
    .next_addr (next_addr)
  );

  // Offset of the last beat within its 1 KB page; beyond 0x3FF it crosses.
  always_comb begin
    cmd_beats = burst_beats(hburst_t'(cmd_burst), cmd_len);
    end_off   = 12'(cmd_addr[9:0]) + (12'(cmd_beats - 5'd1) << cmd_size);
    cmd_bad   = (cmd_size > MAX_SIZE) || (cmd_beats == 5'd0) || (cmd_beats > 5'd16) ||
                (!is_wrap(hburst_t'(cmd_burst)) && (end_off > 12'h3FF));
  end

  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hburst_d    = hburst_q;
    left_d      = left_q;
    dphase_d    = dphase_q;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    to_idle     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d     = S_FIRST;
            htrans_d    = HT_NONSEQ;
            haddr_d     = cmd_addr;
            hwrite_d    = cmd_write;
            hsize_d     = hsize_t'(cmd_size);
            hburst_d    = hburst_t'(cmd_burst);
            left_d      = cmd_beats - 5'd1;
            cmd_ready_d = 1'b0;
          end
        end
      end
      S_FIRST: begin
        if (HREADY) begin
          dphase_d = 1'b1;
          if (left_q != 5'd0) begin
            state_d  = S_BURST;
            htrans_d = HT_SEQ;
            haddr_d  = next_addr;
            left_d   = left_q - 5'd1;
          end else begin
            state_d  = S_LAST;
            htrans_d = HT_IDLE;
          end
        end
      end
      S_BURST, S_LAST: begin
        // An ERROR response ends the burst; a one-cycle response is tolerated too.
        if (HRESP) begin
          htrans_d = HT_IDLE;
          dphase_d = 1'b0;
          if (HREADY) begin
            err_d   = 1'b1;
            to_idle = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end else if (HREADY) begin
          if (state_q == S_LAST) begin
            done_d  = 1'b1;
            to_idle = 1'b1;
          end else if (left_q != 5'd0) begin
            haddr_d = next_addr;
            left_d  = left_q - 5'd1;
          end else begin
            state_d  = S_LAST;
            htrans_d = HT_IDLE;
          end
        end
      end
      S_ERR: begin
        if (HREADY) begin
          err_d   = 1'b1;
          to_idle = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase

    if (to_idle) begin
      state_d     = S_IDLE;
      htrans_d    = HT_IDLE;
      hwrite_d    = 1'b0;
      hsize_d     = HS_BYTE;
      hburst_d    = HB_SINGLE;
      dphase_d    = 1'b0;
      cmd_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      htrans_q    <= HT_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= HS_BYTE;
      hburst_q    <= HB_SINGLE;
      left_q      <= '0;
      dphase_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hburst_q    <= hburst_d;
      left_q      <= left_d;
      dphase_q    <= dphase_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = hburst_q;
  assign HPROT     = 4'b0011;
  assign HWDATA    = wdata;
  assign rd_data   = HRDATA;
  assign wdata_ack = dphase_q && hwrite_q && HREADY && !HRESP;
  assign rd_valid  = dphase_q && !hwrite_q && HREADY && !HRESP;

endmodule
